seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Iterative restoring divider; inverse of the lab5 ROM multiplier (q = da*db).
//  Takes a 2*DATA_WIDTH product-width dividend and a DATA_WIDTH divisor.
//  Returns quotient and remainder after 2*DATA_WIDTH steps, one bit per clock.
//  Uses a start/busy/done handshake so a host FSM or testbench can chain it after the multiplier.
// PARAMETERS
//  DATA_WIDTH  7  operand width; dividend and quotient are 2*DATA_WIDTH bits, divisor and remainder DATA_WIDTH
// PORTS
//  clk       in   1       single clock; all state updates on posedge
//  rst_n     in   1       asynchronous, active-low reset
//  start     in   1       request; sampled only in IDLE
//  dividend  in   2*DW    numerator, captured on the accepting edge
//  divisor   in   DW      denominator, captured on the accepting edge
//  busy      out  1       high in RUN and DONE
//  done      out  1       one-cycle pulse; results valid
//  quotient  out  2*DW    dividend / divisor
//  remainder out  DW      dividend % divisor
//  div_zero  out  1       divisor was 0; valid with done; tied 0 without DIV_ZERO_CHK_EN
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; busy, done and div_zero = 0; quotient and remainder = 0; internal counter = 0.
//  - FSM states:
//    - IDLE -(start)-> RUN, loading the operands, partial remainder r=0 (DW+1 bits) and step counter=2*DW.
//    - RUN -(counter==1 on the step edge)-> DONE.
//    - DONE -> IDLE unconditionally.
//  - RUN step, one per edge, dividend MSB first:
//    - r = {r[DW-1:0], next dividend bit}.
//    - If r >= {1'b0,divisor}: r -= divisor and the quotient bit = 1; otherwise the quotient bit = 0.
//  - Latency: start accepted at edge k; steps run on edges k+1..k+2*DW; done=1 for exactly the cycle after edge k+2*DW.
//  - quotient and remainder (= r[DW-1:0]) update only on entry to DONE. They hold until the next DONE entry or reset.
//  - start while busy (RUN or DONE) is ignored; no queuing.
//  - start in the same cycle done is high is ignored. It is accepted in the next (IDLE) cycle.
//  - Dividend and divisor input changes after acceptance have no effect.
//  - Reset mid-RUN aborts immediately and no done is produced. Outputs return to reset values.
//  - All arithmetic is unsigned. Quotient never overflows, since it is 2*DW wide.
// CONFIGURATION
//  - Macro DIV_ZERO_CHK_EN defined:
//    - divisor==0 at acceptance skips RUN; IDLE -> DONE at edge k+1.
//    - done, div_zero=1, quotient={2*DW{1'b1}}, remainder=dividend[DW-1:0].
//    - div_zero clears on the next start acceptance or reset.
//  - Macro DIV_ZERO_CHK_EN undefined:
//    - divisor==0 runs the full 2*DW steps.
//    - The natural restoring result is identical (quotient all ones, remainder=dividend[DW-1:0]).
//    - div_zero is constant 0.
// STRUCTURE
//  - Package seq_div_pkg:
//    - typedef enum logic[1:0] {S_IDLE,S_RUN,S_DONE} div_state_t.
//    - Function div_steps(DW)=2*DW.
//    - Function cnt_width(DW)=$clog2(2*DW+1).
//  - Sub-module seq_div_step (combinational): input r, dividend bit and divisor; output next r and quotient bit.
//    Instantiated once in the top.
//  - Top module holds the FSM, counter, shift registers and output registers.
// TESTING (DATA_WIDTH=7)
//  1. dividend=100, divisor=7, start 1 cycle -> after 15 cycles done=1, quotient=14, remainder=2, busy low next cycle.
//  2. dividend=16383, divisor=127 -> quotient=129, remainder=0.
//     Also dividend=5, divisor=9 -> quotient=0, remainder=5.
//  3. Sweep all da,db in 0..127, dividend=da*db, divisor=db!=0 -> quotient=da, remainder=0.
//     This is the multiplier round-trip check.
//  4. divisor=0, dividend=0x1234:
//     - With DIV_ZERO_CHK_EN: done 2 cycles after start, div_zero=1, quotient=16383, remainder=0x34.
//     - Without it: same values at 15 cycles, div_zero=0.
//  5. Start 100/7, pulse start with 50/5 at cycle 5 -> ignored; result 14 r2.
//     Start held high through done -> second op begins the cycle after done.
//  6. Assert rst_n=0 at cycle 8 of a run -> busy, done, quotient and remainder = 0 asynchronously.
//     No done pulse; a new start after release works normally.

Source files
------------

// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared FSM state type and sizing helpers for the sequential divider
package seq_div_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;
  function automatic int div_steps(input int dw);
    return 2 * dw;
  endfunction
  function automatic int cnt_width(input int dw);
    return $clog2(2 * dw + 1);
  endfunction
endpackage

// File: rtl/seq_div_step.sv
// seq_div_step: one combinational restoring-division step (shift in a dividend bit, trial subtract)
//   r       in  DW  partial remainder, always below divisor so DW bits suffice
//   bit_in  in  1   next dividend bit, MSB first
//   divisor in  DW  denominator
//   r_next  out DW  updated partial remainder
//   q_bit   out 1   quotient bit produced by this step
module seq_div_step
  import seq_div_pkg::*;
#(
  parameter int DW = 7
) (
  input  logic [DW-1:0] r,
  input  logic          bit_in,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] r_next,
  output logic          q_bit
);
  logic [DW:0] sh;
  // The subtraction result is below divisor, so it is exact modulo 2^DW.
  always_comb begin
    sh = {r, bit_in};
    q_bit = sh >= {1'b0, divisor};
    r_next = q_bit ? sh[DW-1:0] - divisor : sh[DW-1:0];
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, 2*DATA_WIDTH-bit dividend by DATA_WIDTH-bit divisor, one bit per clock
//   clk       in  1      clock, posedge
//   rst_n     in  1      asynchronous active-low reset
//   start     in  1      request, sampled only in IDLE
//   dividend  in  2*DW   numerator, captured on acceptance
//   divisor   in  DW     denominator, captured on acceptance
//   busy      out 1      high in RUN and DONE
//   done      out 1      one-cycle result-valid pulse
//   quotient  out 2*DW   dividend / divisor
//   remainder out DW     dividend % divisor
//   div_zero  out 1      divisor was zero; constant 0 unless DIV_ZERO_CHK_EN is defined
// Optional macro DIV_ZERO_CHK_EN: a zero divisor skips RUN and flags div_zero.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int DATA_WIDTH = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [2*DATA_WIDTH-1:0]   dividend,
  input  logic [DATA_WIDTH-1:0]     divisor,
  output logic                      busy,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   quotient,
  output logic [DATA_WIDTH-1:0]     remainder,
  output logic                      div_zero
);
  localparam int DW = DATA_WIDTH;
  localparam int W2 = div_steps(DATA_WIDTH);
  localparam int CW = cnt_width(DATA_WIDTH);
  div_state_t state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] r, dvs, r_nxt;
  // Dividend bits leave at the top while quotient bits enter at the bottom.
  logic [W2-1:0] acc;
  logic q_bit;
  seq_div_step #(.DW(DW)) u_step (
    .r(r),
    .bit_in(acc[W2-1]),
    .divisor(dvs),
    .r_next(r_nxt),
    .q_bit(q_bit)
  );
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
`ifdef DIV_ZERO_CHK_EN
  logic dz;
  assign div_zero = dz;
`else
  assign div_zero = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      r <= '0;
      dvs <= '0;
      acc <= '0;
      quotient <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_CHK_EN
      dz <= 1'b0;
`endif
    end else if (state == S_IDLE && start) begin
      acc <= dividend;
      dvs <= divisor;
      r <= '0;
      cnt <= CW'(W2);
`ifdef DIV_ZERO_CHK_EN
      dz <= divisor == '0;
      if (divisor == '0) begin
        state <= S_DONE;
        quotient <= '1;
        remainder <= dividend[DW-1:0];
      end else begin
        state <= S_RUN;
      end
`else
      state <= S_RUN;
`endif
    end else if (state == S_RUN) begin
      acc <= {acc[W2-2:0], q_bit};
      r <= r_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state <= S_DONE;
        quotient <= {acc[W2-2:0], q_bit};
        remainder <= r_nxt;
      end
    end else if (state == S_DONE) begin
      state <= S_IDLE;
    end
  end
endmodule
